countdown_display_driver: RTL and testbench

- Consumes the traffic controller's two 2-digit BCD countdowns and A/B light states; drives a 4-digit multiplexed seven-segment display.
- Digits 0-1 show side A (tens, ones); digits 2-3 show side B.
- Scans one digit at a time with a ghost-guard blank slot. Snapshots inputs once per frame so a frame never mixes old and new counts.
- Suppresses leading zeros, shows a dash for invalid BCD, and blinks a side's digits during the last seconds of its green.

---
 rtl/countdown_display_driver_if.sv | 31 +++
 rtl/countdown_display_driver.sv | 152 +++++++++++++++
 tb/tb_countdown_display_driver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_display_driver_if.sv
// Display driver bundle: countdown/light inputs and the multiplexed
// seven-segment outputs, with a producer (master) and driver (slave) view.
interface countdown_display_driver_if;
    logic [7:0] nOut1;
    logic [7:0] nOut2;
    logic       A_Light;
    logic       B_Light;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;

    modport master (
        output nOut1,
        output nOut2,
        output A_Light,
        output B_Light,
        input  AN,
        input  SEG,
        input  DP
    );

    modport slave (
        input  nOut1,
        input  nOut2,
        input  A_Light,
        input  B_Light,
        output AN,
        output SEG,
        output DP
    );
endinterface

// File: rtl/countdown_display_driver.sv
// Four-digit multiplexed seven-segment driver for two BCD countdowns with
// per-frame input snapshot, ghost-guard slot, zero suppression and blink.
module countdown_display_driver #(
    parameter int SCAN_DIV     = 8,
    parameter int BLINK_FRAMES = 4,
    parameter int BLINK_THRESH = 5
) (
    input  logic                     CLK,
    input  logic                     R,
    countdown_display_driver_if.slave io
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    THRESH   = 7'(BLINK_THRESH);

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;
    logic [7:0]    snap_a_q, snap_a_d;
    logic [7:0]    snap_b_q, snap_b_d;
    logic          lt_a_q, lt_a_d;
    logic          lt_b_q, lt_b_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          slot_end;
    logic          frame_end;
    logic [7:0]    side_v;
    logic          side_lt;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [3:0]    nib;
    logic          valid;
    logic [6:0]    value;
    logic          blink_off;
    logic [6:0]    code;

    function automatic logic [6:0] bcd_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Scan counters, frame/blink bookkeeping and snapshot capture
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (dig_q == 2'd3);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        dig_d     = slot_end ? dig_q + 2'd1 : dig_q;
        frm_d     = frm_q;
        phase_d   = phase_q;
        snap_a_d  = snap_a_q;
        snap_b_d  = snap_b_q;
        lt_a_d    = lt_a_q;
        lt_b_d    = lt_b_q;
        if (frame_end) begin
            snap_a_d = io.nOut1;
            snap_b_d = io.nOut2;
            lt_a_d   = io.A_Light;
            lt_b_d   = io.B_Light;
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    // Outputs are computed from the post-edge state so the first slot of a
    // frame already sees the freshly captured snapshot and blink phase.
    always_comb begin
        side_v    = dig_d[1] ? snap_b_d : snap_a_d;
        side_lt   = dig_d[1] ? lt_b_d : lt_a_d;
        tens      = side_v[7:4];
        ones      = side_v[3:0];
        nib       = dig_d[0] ? ones : tens;
        valid     = (tens <= 4'd9) && (ones <= 4'd9);
        value     = {3'b000, tens} * 7'd10 + {3'b000, ones};
        blink_off = side_lt && valid && phase_d &&
                    (value >= 7'd1) && (value <= THRESH);
        code      = SEG_BLANK;
        if (!valid) begin
            code = SEG_DASH;
        end else if (blink_off) begin
            code = SEG_BLANK;
        end else if (!dig_d[0] && (tens == 4'd0)) begin
            code = SEG_BLANK;
        end else begin
            code = bcd_seg(nib);
        end
        an_d  = 4'b0000;
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (cnt_d != CNT_LAST) begin
            an_d  = 4'b0001 << dig_d;
            seg_d = code;
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            cnt_q    <= '0;
            dig_q    <= '0;
            frm_q    <= '0;
            phase_q  <= 1'b0;
            snap_a_q <= '0;
            snap_b_q <= '0;
            lt_a_q   <= 1'b0;
            lt_b_q   <= 1'b0;
            an_q     <= '0;
            seg_q    <= '0;
            dp_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            frm_q    <= frm_d;
            phase_q  <= phase_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
            lt_a_q   <= lt_a_d;
            lt_b_q   <= lt_b_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign io.AN  = an_q;
    assign io.SEG = seg_q;
    assign io.DP  = dp_q;
endmodule

// File: tb/tb_countdown_display_driver.sv
// Randomized bench for countdown_display_driver against a timeline model
// derived from the edge count since reset release.
module tb_countdown_display_driver;
    localparam int SD = 8;
    localparam int BF = 4;
    localparam int TH = 5;
    localparam int FR = 4 * SD;

    logic CLK = 1'b0;
    logic R   = 1'b1;

    countdown_display_driver_if io ();

    countdown_display_driver #(
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF),
        .BLINK_THRESH(TH)
    ) dut (
        .CLK(CLK),
        .R  (R),
        .io (io)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    int         m_t  = 0;
    logic [7:0] m_a  = '0;
    logic [7:0] m_b  = '0;
    logic       m_la = 1'b0;
    logic       m_lb = 1'b0;
    logic [3:0] e_an = '0;
    logic [6:0] e_seg = '0;

    function automatic logic [6:0] code(input int n);
        case (n)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [6:0] side_digit(input logic [7:0] v,
                                              input logic lt,
                                              input bit is_ones,
                                              input bit ph);
        int t;
        int o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        if (t > 9 || o > 9) return 7'h40;
        if (lt && ph && (t * 10 + o) >= 1 && (t * 10 + o) <= TH) return 7'h00;
        if (!is_ones && t == 0) return 7'h00;
        return code(is_ones ? o : t);
    endfunction

    // Timeline model: edge t since release -> slot, frame, blink phase.
    initial forever begin
        int  c;
        int  dg;
        int  f;
        bit  ph;
        @(posedge CLK or posedge R);
        if (R) begin
            m_t = 0; m_a = '0; m_b = '0; m_la = 1'b0; m_lb = 1'b0;
            e_an = '0; e_seg = '0;
        end else begin
            m_t = m_t + 1;
            if (m_t % FR == 0) begin
                m_a = io.nOut1; m_b = io.nOut2;
                m_la = io.A_Light; m_lb = io.B_Light;
            end
            c  = m_t % SD;
            dg = (m_t / SD) % 4;
            f  = m_t / FR;
            ph = ((f / BF) % 2) == 1;
            if (c == SD - 1) begin
                e_an = '0; e_seg = '0;
            end else begin
                e_an  = 4'(1 << dg);
                e_seg = side_digit(dg < 2 ? m_a : m_b, dg < 2 ? m_la : m_lb,
                                   (dg % 2) == 1, ph);
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        tests++;
        if (io.AN !== e_an || io.SEG !== e_seg || io.DP !== 1'b0) begin
            fails++;
            $display("FAIL scan t=%0d: got AN=%b SEG=%h DP=%b, want AN=%b SEG=%h DP=0",
                     m_t, io.AN, io.SEG, io.DP, e_an, e_seg);
        end
    end

    task automatic goto(input int f, input int d, input int c, output bit ok);
        int k;
        k = 0;
        while (!((m_t / FR) == f && ((m_t / SD) % 4) == d && (m_t % SD) == c)
               && k < 4000) begin
            @(negedge CLK);
            k++;
        end
        ok = (k < 4000);
    endtask

    task automatic lit(input string nm, input int f, input int d,
                       input logic [6:0] want);
        bit ok;
        goto(f, d, 2, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: timeout waiting for frame %0d digit %0d", nm, f, d);
        end else if (io.SEG !== want || io.AN !== 4'(1 << d)) begin
            fails++;
            $display("FAIL %s: got SEG=%h AN=%b, want SEG=%h AN=%b",
                     nm, io.SEG, io.AN, want, 4'(1 << d));
        end
    endtask

    function automatic logic [7:0] rnd_cnt();
        if ($urandom_range(0, 9) == 0) return 8'($urandom);
        return {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        bit ok;
        int fr;
        io.nOut1 = '0; io.nOut2 = '0;
        io.A_Light = 1'b0; io.B_Light = 1'b0;
        repeat (3) @(negedge CLK);
        R = 1'b0;

        lit("f0_tens_a", 0, 0, 7'h00);
        lit("f0_ones_a", 0, 1, 7'h3F);
        lit("f0_tens_b", 0, 2, 7'h00);
        lit("f0_ones_b", 0, 3, 7'h3F);
        io.nOut1 = 8'h42; io.nOut2 = 8'h17;

        lit("snap_d0", 1, 0, 7'h66);
        io.nOut1 = 8'h99;
        lit("snap_d1", 1, 1, 7'h5B);
        lit("snap_d2", 1, 2, 7'h06);
        lit("snap_d3", 1, 3, 7'h07);
        lit("new_d0", 2, 0, 7'h6F);
        lit("new_d1", 2, 1, 7'h6F);
        io.nOut1 = 8'h3C;

        lit("inv_d0", 3, 0, 7'h40);
        lit("inv_d1", 3, 1, 7'h40);
        lit("inv_b_d2", 3, 2, 7'h06);
        lit("inv_b_d3", 3, 3, 7'h07);
        io.A_Light = 1'b1; io.nOut1 = 8'h04;

        lit("blink_off_d0", 4, 0, 7'h00);
        lit("blink_off_d1", 4, 1, 7'h00);
        lit("blink_on_d1", 8, 1, 7'h66);
        lit("blink_off2_d1", 12, 1, 7'h00);
        io.nOut1 = 8'h06;
        lit("no_blink_6", 13, 1, 7'h7D);
        io.A_Light = 1'b0; io.nOut1 = 8'h04;
        lit("no_blink_red", 14, 1, 7'h66);
        io.A_Light = 1'b1; io.nOut1 = 8'h05;
        lit("blink_thresh", 15, 1, 7'h00);
        io.nOut1 = 8'h10; io.nOut2 = 8'h01; io.B_Light = 1'b1;
        lit("b_blink_on", 16, 3, 7'h06);
        lit("a_ten_d0", 20, 0, 7'h06);
        lit("a_ten_d1", 20, 1, 7'h3F);
        lit("b_blink_off", 20, 3, 7'h00);
        io.nOut2 = 8'h00;
        lit("b_zero_tens", 21, 2, 7'h00);
        lit("b_zero_ones", 21, 3, 7'h3F);

        for (int i = 0; i < 40 * FR; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 7) == 0) begin
                io.nOut1 = rnd_cnt();
                io.nOut2 = rnd_cnt();
                io.A_Light = 1'($urandom_range(0, 1));
                io.B_Light = 1'($urandom_range(0, 1));
            end
        end

        io.nOut1 = 8'h88; io.nOut2 = 8'h88;
        fr = m_t / FR;
        goto(fr + 1, 2, 3, ok);
        #2 R = 1'b1;
        #1;
        tests++;
        if (!ok || io.AN !== 4'b0000 || io.SEG !== 7'h00 || io.DP !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: reached=%0b AN=%b SEG=%h DP=%b, want AN=0000 SEG=00 DP=0",
                     ok, io.AN, io.SEG, io.DP);
        end
        repeat (2) @(negedge CLK);
        R = 1'b0;
        lit("rst_d0", 0, 0, 7'h00);
        lit("rst_d1", 0, 1, 7'h3F);
        lit("rst_d2", 0, 2, 7'h00);
        lit("rst_new_d0", 1, 0, 7'h7F);
        lit("rst_new_d1", 1, 1, 7'h7F);
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
